// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage: PC register, IF/ID register, stall/redirect and trap halt.     |
// | Optional: BRANCH_DELAY_SLOT_EN (branch-cycle word kept, no flush).          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [0:31] RESET_PC  = 32'h00000000,
    parameter logic [0:31] NOP_INSTR = 32'h54000000,
    parameter logic [0:31] TRAP_HALT = 32'h44000300
) (
    input  logic        clock,
    input  logic        reset,
    output logic [0:31] imem_addr,
    input  logic [0:31] imem_data,
    input  logic        stall,
    input  logic        branch,
    input  logic [0:31] branch_target,
    output logic        stallack,
    output logic [0:31] if_id_instr,
    output logic [0:31] if_id_pc4,
    output logic [0:31] pcout,
    output logic        halted,
    output logic [0:31] fetch_count
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit FLUSH_EN = 1'b0;
`else
    localparam bit FLUSH_EN = 1'b1;
`endif

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [0:31] pc, pc_next, pc_plus4;
    logic [0:31] instr_next, pc4_next, count_next;
    logic        flush;

    assign pc_plus4  = pc + 32'd4;
    assign flush     = branch && FLUSH_EN;
    assign imem_addr = pc;
    assign pcout     = pc;
    assign halted    = (state == HALTED);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = if_id_instr;
        pc4_next   = if_id_pc4;
        count_next = fetch_count;
        case (state)
            RUN: begin
                if (!stall) begin
                    pc4_next = pc_plus4;
                    pc_next  = branch ? branch_target : pc_plus4;
                    if (flush) begin
                        instr_next = NOP_INSTR;
                    end else begin
                        instr_next = imem_data;
                        count_next = fetch_count + 32'd1;
                        if (imem_data == TRAP_HALT)
                            state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!stall) begin
                    instr_next = NOP_INSTR;
                    // A taken branch means the trap was only a shadow fetch.
                    if (flush) begin
                        pc_next    = branch_target;
                        state_next = RUN;
                    end else begin
                        state_next = HALTED;
                    end
                end
            end
            HALTED: begin
                instr_next = NOP_INSTR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'd0;
            fetch_count <= 32'd0;
            stallack    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_id_instr <= instr_next;
            if_id_pc4   <= pc4_next;
            fetch_count <= count_next;
            stallack    <= stall;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage: directed vectors with hand-computed expectations.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [31:0] NOP  = 32'h54000000;
    localparam logic [31:0] TRAP = 32'h44000300;

    logic        clock;
    logic        reset;
    logic [0:31] imem_addr;
    logic [0:31] imem_data;
    logic        stall;
    logic        branch;
    logic [0:31] branch_target;
    logic        stallack;
    logic [0:31] if_id_instr;
    logic [0:31] if_id_pc4;
    logic [0:31] pcout;
    logic        halted;
    logic [0:31] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic [31:0] addr_flat;

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch        (branch),
        .branch_target (branch_target),
        .stallack      (stallack),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .pcout         (pcout),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always_comb begin
        addr_flat = imem_addr;
        imem_data = mem[addr_flat[9:2]];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 + i;
        mem[0] = 32'h20010005;
        mem[1] = 32'h20020007;
        mem[2] = 32'h2003000A;
        mem[3] = 32'h2004000B;
        mem[4] = 32'h2005000C;
        mem[7] = TRAP;
        reset = 1'b0; stall = 1'b0; branch = 1'b0; branch_target = 32'h0;

        // Reset state
        tick(); tick();
        check("rst_pc", pcout, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", if_id_instr, NOP);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_stallack", {31'd0, stallack}, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'h0);
        reset = 1'b1;

        // Sequential fetch
        tick();
        check("seq1_pc", pcout, 32'h4);
        check("seq1_instr", if_id_instr, 32'h20010005);
        check("seq1_pc4", if_id_pc4, 32'h4);
        tick();
        check("seq2_pc", pcout, 32'h8);
        check("seq2_instr", if_id_instr, 32'h20020007);
        check("seq2_pc4", if_id_pc4, 32'h8);
        check("seq2_count", fetch_count, 32'h2);

        // Stall for three edges
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pcout, 32'h8);
            check("stall_addr", imem_addr, 32'h8);
            check("stall_instr", if_id_instr, 32'h20020007);
            check("stall_count", fetch_count, 32'h2);
            check("stall_ack", {31'd0, stallack}, 32'h1);
        end
        stall = 1'b0;
        tick();
        check("resume_ack", {31'd0, stallack}, 32'h0);
        check("resume_pc", pcout, 32'hC);
        check("resume_instr", if_id_instr, 32'h2003000A);
        check("resume_count", fetch_count, 32'h3);
        tick();
        check("pre_br_pc", pcout, 32'h10);

        // Taken branch at 0x10
        branch = 1'b1; branch_target = 32'h40;
        tick();
        check("br_pc", pcout, 32'h40);
        check("br_instr", if_id_instr, DS ? 32'h2005000C : NOP);
        check("br_count", fetch_count, DS ? 32'h5 : 32'h4);
        check("br_pc4", if_id_pc4, 32'h14);

        // Stall and branch together: branch ignored
        stall = 1'b1; branch = 1'b1; branch_target = 32'h80;
        tick();
        check("stbr_pc", pcout, 32'h40);
        check("stbr_ack", {31'd0, stallack}, 32'h1);
        stall = 1'b0;
        tick();
        check("stbr_redirect_pc", pcout, 32'h80);
        check("stbr_instr", if_id_instr, DS ? 32'h10000010 : NOP);
        check("stbr_count", fetch_count, DS ? 32'h6 : 32'h4);
        branch = 1'b0;

        // Trap halt at 0x1C
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        check("pre_trap_pc", pcout, 32'h1C);
        tick();
        check("trap_instr", if_id_instr, TRAP);
        check("trap_pc", pcout, 32'h20);
        check("trap_halted0", {31'd0, halted}, 32'h0);
        check("trap_count", fetch_count, 32'h8);
        tick();
        check("halt_instr", if_id_instr, NOP);
        check("halt_halted", {31'd0, halted}, 32'h1);
        check("halt_pc", pcout, 32'h20);
        branch = 1'b1; branch_target = 32'h0; stall = 1'b1;
        tick();
        check("halt_br_pc", pcout, 32'h20);
        check("halt_br_addr", imem_addr, 32'h20);
        check("halt_br_halted", {31'd0, halted}, 32'h1);
        check("halt_stallack", {31'd0, stallack}, 32'h1);
        check("halt_count", fetch_count, 32'h8);
        branch = 1'b0; stall = 1'b0;

        // Trap at 0x14 cancelled by a taken branch while draining
        mem[5] = TRAP;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        check("cancel_trap_instr", if_id_instr, TRAP);
        check("cancel_trap_count", fetch_count, 32'h6);
        branch = 1'b1; branch_target = 32'h100;
        tick();
        branch = 1'b0;
        check("cancel_pc", pcout, DS ? 32'h18 : 32'h100);
        check("cancel_halted", {31'd0, halted}, DS ? 32'h1 : 32'h0);
        check("cancel_instr", if_id_instr, NOP);
        tick();
        check("cancel_next_pc", pcout, DS ? 32'h18 : 32'h104);
        check("cancel_next_instr", if_id_instr, DS ? NOP : 32'h10000040);
        check("cancel_next_count", fetch_count, DS ? 32'h6 : 32'h7);

        // Reset during DRAIN
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        check("mid_trap_instr", if_id_instr, TRAP);
        reset = 1'b0; stall = 1'b1;
        tick();
        check("mid_pc", pcout, 32'h0);
        check("mid_halted", {31'd0, halted}, 32'h0);
        check("mid_count", fetch_count, 32'h0);
        check("mid_instr", if_id_instr, NOP);
        check("mid_ack", {31'd0, stallack}, 32'h0);
        reset = 1'b1; stall = 1'b0;
        tick();
        check("mid_refetch_instr", if_id_instr, 32'h20010005);
        check("mid_refetch_pc", pcout, 32'h4);

        // PC wrap from 0xFFFFFFFC
        branch = 1'b1; branch_target = 32'hFFFFFFFC;
        tick();
        branch = 1'b0;
        check("wrap_target_pc", pcout, 32'hFFFFFFFC);
        tick();
        check("wrap_pc", pcout, 32'h0);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_instr", if_id_instr, 32'h100000FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
